// File: rtl/logic_seq_pkg.sv
// Shared types and helpers for the 4053 select sequencer.
// Holds the FSM state encoding, the table entry layout and the dwell clamp.
package logic_seq_pkg;

    localparam int SEQ_DWELL_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BREAK = 2'd1,
        HOLD  = 2'd2
    } seq_state_t;

    typedef struct packed {
        logic [2:0]             sel;
        logic [SEQ_DWELL_W-1:0] dwell;
    } seq_entry_t;

    // A programmed dwell of zero still holds the entry for one cycle.
    function automatic logic [31:0] dwell_eff(input logic [31:0] d);
        logic [31:0] r;
        if (d == 32'd0) begin
            r = 32'd1;
        end else begin
            r = d;
        end
        return r;
    endfunction

endpackage

// File: rtl/logic_seq_table.sv
// Pattern table for the 4053 sequencer: DEPTH entries of {sel, dwell}.
// The read port bypasses a same-cycle write so a start in the write cycle sees new data.
module logic_seq_table #(
    parameter  int DEPTH   = 8,
    parameter  int DWELL_W = 16,
    localparam int IDX_W   = $clog2(DEPTH)
) (
    input  logic               CLK,
    input  logic               wr_en,
    input  logic [IDX_W-1:0]   wr_addr,
    input  logic [2:0]         wr_sel,
    input  logic [DWELL_W-1:0] wr_dwell,
    input  logic [IDX_W-1:0]   rd_addr,
    output logic [2:0]         rd_sel,
    output logic [DWELL_W-1:0] rd_dwell
);

    logic [2:0]         sel_mem_r   [DEPTH];
    logic [DWELL_W-1:0] dwell_mem_r [DEPTH];

    // Table storage; intentionally not reset.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            sel_mem_r[wr_addr]   <= wr_sel;
            dwell_mem_r[wr_addr] <= wr_dwell;
        end
    end

    // Write-first read port.
    always_comb begin
        rd_sel   = sel_mem_r[rd_addr];
        rd_dwell = dwell_mem_r[rd_addr];
        if (wr_en && (wr_addr == rd_addr)) begin
            rd_sel   = wr_sel;
            rd_dwell = wr_dwell;
        end else begin
            rd_sel   = sel_mem_r[rd_addr];
            rd_dwell = dwell_mem_r[rd_addr];
        end
    end

endmodule

// File: rtl/logic_4053_sequencer.sv
// Break-before-make sequencer driving INH/A/B/C of a 4053 triple 2:1 switch.
// Walks a pattern table; INH stays high for BREAK_CYC cycles around every select change.
module logic_4053_sequencer
    import logic_seq_pkg::*;
#(
    parameter  int DEPTH     = 8,
    parameter  int DWELL_W   = SEQ_DWELL_W,
    parameter  int BREAK_CYC = 2,
    localparam int IDX_W     = $clog2(DEPTH)
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               START,
    input  logic               STOP,
    input  logic               LOOP,
    input  logic [IDX_W-1:0]   LEN,
    input  logic               WR_EN,
    input  logic [IDX_W-1:0]   WR_ADDR,
    input  logic [2:0]         WR_SEL,
    input  logic [DWELL_W-1:0] WR_DWELL,
    output logic               INH,
    output logic               A,
    output logic               B,
    output logic               C,
    output logic               BUSY,
    output logic [IDX_W-1:0]   STEP_IDX,
    output logic               STEP_STB,
    output logic               DONE
);

    localparam int BRK_W = (BREAK_CYC > 1) ? $clog2(BREAK_CYC) : 1;
    localparam logic [BRK_W-1:0] BRK_INIT = BRK_W'(BREAK_CYC - 1);

    seq_state_t         state_r;
    logic [IDX_W-1:0]   idx_r;
    logic [IDX_W-1:0]   len_r;
    logic [BRK_W-1:0]   brk_cnt_r;
    logic [DWELL_W-1:0] dwell_cnt_r;

    logic               tbl_wr_s;
    logic [IDX_W-1:0]   rd_addr_s;
    logic [2:0]         rd_sel_s;
    logic [DWELL_W-1:0] rd_dwell_s;
    logic [DWELL_W-1:0] dwell_m1_s;
    logic [IDX_W-1:0]   next_idx_s;
    logic               last_s;
    logic               same_sel_s;

    assign tbl_wr_s = WR_EN & ~BUSY;
    assign STEP_IDX = idx_r;

    logic_seq_table #(
        .DEPTH   (DEPTH),
        .DWELL_W (DWELL_W)
    ) u_table (
        .CLK      (CLK),
        .wr_en    (tbl_wr_s),
        .wr_addr  (WR_ADDR),
        .wr_sel   (WR_SEL),
        .wr_dwell (WR_DWELL),
        .rd_addr  (rd_addr_s),
        .rd_sel   (rd_sel_s),
        .rd_dwell (rd_dwell_s)
    );

    // Read address: entry 0 while idle, the current entry in BREAK, the upcoming one in HOLD.
    always_comb begin
        last_s     = (idx_r == len_r);
        next_idx_s = last_s ? '0 : (idx_r + IDX_W'(1'b1));
        rd_addr_s  = '0;
        case (state_r)
            IDLE:    rd_addr_s = '0;
            BREAK:   rd_addr_s = idx_r;
            HOLD:    rd_addr_s = next_idx_s;
            default: rd_addr_s = '0;
        endcase
        dwell_m1_s = DWELL_W'(dwell_eff(32'(rd_dwell_s)) - 32'd1);
        same_sel_s = (rd_sel_s == {C, B, A});
    end

    // Sequencer FSM, counters and registered switch controls.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_r     <= IDLE;
            idx_r       <= '0;
            len_r       <= '0;
            brk_cnt_r   <= '0;
            dwell_cnt_r <= '0;
            INH         <= 1'b1;
            {C, B, A}   <= 3'b000;
            BUSY        <= 1'b0;
            STEP_STB    <= 1'b0;
            DONE        <= 1'b0;
        end else if (STOP) begin
            state_r  <= IDLE;
            INH      <= 1'b1;
            BUSY     <= 1'b0;
            STEP_STB <= 1'b0;
            DONE     <= 1'b0;
        end else begin
            STEP_STB <= 1'b0;
            DONE     <= 1'b0;
            case (state_r)
                IDLE: begin
                    INH <= 1'b1;
                    if (START) begin
                        len_r     <= LEN;
                        idx_r     <= '0;
                        {C, B, A} <= rd_sel_s;
                        brk_cnt_r <= BRK_INIT;
                        BUSY      <= 1'b1;
                        state_r   <= BREAK;
                    end
                end
                BREAK: begin
                    if (brk_cnt_r == '0) begin
                        dwell_cnt_r <= dwell_m1_s;
                        INH         <= 1'b0;
                        STEP_STB    <= 1'b1;
                        state_r     <= HOLD;
                    end else begin
                        brk_cnt_r <= brk_cnt_r - BRK_W'(1'b1);
                    end
                end
                HOLD: begin
                    if (dwell_cnt_r != '0) begin
                        dwell_cnt_r <= dwell_cnt_r - DWELL_W'(1'b1);
                    end else if (last_s && !LOOP) begin
                        DONE    <= 1'b1;
                        INH     <= 1'b1;
                        BUSY    <= 1'b0;
                        state_r <= IDLE;
                    end else begin
                        idx_r <= next_idx_s;
                        // Unchanged selects need no break interval: stay connected.
                        if (same_sel_s) begin
                            dwell_cnt_r <= dwell_m1_s;
                            STEP_STB    <= 1'b1;
                        end else begin
                            {C, B, A} <= rd_sel_s;
                            INH       <= 1'b1;
                            brk_cnt_r <= BRK_INIT;
                            state_r   <= BREAK;
                        end
                    end
                end
                default: begin
                    INH     <= 1'b1;
                    BUSY    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_logic_4053_sequencer.sv
// Directed self-checking bench for logic_4053_sequencer.
// Expected per-cycle output vectors are hand-derived {INH,C,B,A,STEP_STB,DONE,BUSY,STEP_IDX}.
module tb_logic_4053_sequencer;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        START;
    logic        STOP;
    logic        LOOP;
    logic [2:0]  LEN;
    logic        WR_EN;
    logic [2:0]  WR_ADDR;
    logic [2:0]  WR_SEL;
    logic [15:0] WR_DWELL;
    logic        INH;
    logic        A;
    logic        B;
    logic        C;
    logic        BUSY;
    logic [2:0]  STEP_IDX;
    logic        STEP_STB;
    logic        DONE;

    int n_checks = 0;
    int n_fail   = 0;
    logic [9:0] exp_q[$];
    logic [9:0] obs_s;

    assign obs_s = {INH, C, B, A, STEP_STB, DONE, BUSY, STEP_IDX};

    logic_4053_sequencer dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .START    (START),
        .STOP     (STOP),
        .LOOP     (LOOP),
        .LEN      (LEN),
        .WR_EN    (WR_EN),
        .WR_ADDR  (WR_ADDR),
        .WR_SEL   (WR_SEL),
        .WR_DWELL (WR_DWELL),
        .INH      (INH),
        .A        (A),
        .B        (B),
        .C        (C),
        .BUSY     (BUSY),
        .STEP_IDX (STEP_IDX),
        .STEP_STB (STEP_STB),
        .DONE     (DONE)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] pk(input logic inh, input logic [2:0] abc, input logic stb,
                                      input logic done, input logic busy, input logic [2:0] idx);
        return {inh, abc, stb, done, busy, idx};
    endfunction

    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic wr(input logic [2:0] addr, input logic [2:0] sel, input logic [15:0] dwell);
        WR_EN    = 1'b1;
        WR_ADDR  = addr;
        WR_SEL   = sel;
        WR_DWELL = dwell;
        tick();
        WR_EN = 1'b0;
    endtask

    task automatic go(input logic [2:0] len);
        LEN   = len;
        START = 1'b1;
        tick();
        START = 1'b0;
    endtask

    task automatic run_trace(input string name);
        for (int i = 0; i < exp_q.size(); i++) begin
            check_eq($sformatf("%s_c%0d", name, i + 1), 32'(obs_s), 32'(exp_q[i]));
            tick();
        end
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_stb;
        int n_done;
        int order_err;
        RST_N = 1'b0; START = 1'b0; STOP = 1'b0; LOOP = 1'b0; LEN = 3'd0;
        WR_EN = 1'b0; WR_ADDR = 3'd0; WR_SEL = 3'd0; WR_DWELL = 16'd0;
        tick();
        tick();
        check_eq("reset", 32'(obs_s), 32'(pk(1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0)));
        RST_N = 1'b1;
        tick();
        check_eq("idle", 32'(obs_s), 32'(pk(1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0)));

        // Two entries with different selects, non-looping.
        wr(3'd0, 3'b001, 16'd4);
        wr(3'd1, 3'b110, 16'd2);
        go(3'd1);
        exp_q = '{pk(1,3'b001,0,0,1,3'd0), pk(1,3'b001,0,0,1,3'd0),
                  pk(0,3'b001,1,0,1,3'd0), pk(0,3'b001,0,0,1,3'd0),
                  pk(0,3'b001,0,0,1,3'd0), pk(0,3'b001,0,0,1,3'd0),
                  pk(1,3'b110,0,0,1,3'd1), pk(1,3'b110,0,0,1,3'd1),
                  pk(0,3'b110,1,0,1,3'd1), pk(0,3'b110,0,0,1,3'd1),
                  pk(1,3'b110,0,1,0,3'd1), pk(1,3'b110,0,0,0,3'd1)};
        run_trace("basic");

        // Equal selects: second entry skips the break interval.
        wr(3'd0, 3'b101, 16'd3);
        wr(3'd1, 3'b101, 16'd3);
        go(3'd1);
        exp_q = '{pk(1,3'b101,0,0,1,3'd0), pk(1,3'b101,0,0,1,3'd0),
                  pk(0,3'b101,1,0,1,3'd0), pk(0,3'b101,0,0,1,3'd0),
                  pk(0,3'b101,0,0,1,3'd0), pk(0,3'b101,1,0,1,3'd1),
                  pk(0,3'b101,0,0,1,3'd1), pk(0,3'b101,0,0,1,3'd1),
                  pk(1,3'b101,0,1,0,3'd1)};
        run_trace("skip");

        // Looping: 20 strobes alternating 0,1 and no DONE, then drop LOOP in entry 1.
        wr(3'd0, 3'b001, 16'd4);
        wr(3'd1, 3'b110, 16'd2);
        LOOP = 1'b1;
        go(3'd1);
        n_stb = 0; n_done = 0; order_err = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (DONE) n_done++;
            if (STEP_STB) begin
                if (STEP_IDX != 3'(n_stb % 2)) order_err++;
                n_stb++;
            end
            if (n_stb >= 20) break;
            tick();
        end
        check_eq("loop_strobes", 32'(n_stb), 32'd20);
        check_eq("loop_order_err", 32'(order_err), 32'd0);
        check_eq("loop_done", 32'(n_done), 32'd0);
        LOOP = 1'b0;
        tick();
        exp_q = '{pk(0,3'b110,0,0,1,3'd1), pk(1,3'b110,0,1,0,3'd1)};
        run_trace("loop_exit");

        // STOP in the second HOLD cycle of entry 0.
        go(3'd1);
        exp_q = '{pk(1,3'b001,0,0,1,3'd0), pk(1,3'b001,0,0,1,3'd0),
                  pk(0,3'b001,1,0,1,3'd0)};
        run_trace("stop_pre");
        check_eq("stop_hold2", 32'(obs_s), 32'(pk(0,3'b001,0,0,1,3'd0)));
        STOP = 1'b1;
        tick();
        STOP = 1'b0;
        exp_q = '{pk(1,3'b001,0,0,0,3'd0), pk(1,3'b001,0,0,0,3'd0)};
        run_trace("stop_post");

        // Write-first START with dwell 0, LEN 0; a write while busy must be dropped.
        WR_EN = 1'b1; WR_ADDR = 3'd0; WR_SEL = 3'b010; WR_DWELL = 16'd0;
        LEN = 3'd0; START = 1'b1;
        tick();
        WR_EN = 1'b0; START = 1'b0;
        check_eq("wfirst_c1", 32'(obs_s), 32'(pk(1,3'b010,0,0,1,3'd0)));
        WR_EN = 1'b1; WR_ADDR = 3'd0; WR_SEL = 3'b111; WR_DWELL = 16'd5;
        tick();
        WR_EN = 1'b0;
        exp_q = '{pk(1,3'b010,0,0,1,3'd0), pk(0,3'b010,1,0,1,3'd0),
                  pk(1,3'b010,0,1,0,3'd0), pk(1,3'b010,0,0,0,3'd0)};
        run_trace("dwell0");
        go(3'd0);
        exp_q = '{pk(1,3'b010,0,0,1,3'd0), pk(1,3'b010,0,0,1,3'd0),
                  pk(0,3'b010,1,0,1,3'd0), pk(1,3'b010,0,1,0,3'd0)};
        run_trace("busy_wr");

        // Reset mid-HOLD, then a fresh START.
        wr(3'd0, 3'b001, 16'd4);
        go(3'd1);
        exp_q = '{pk(1,3'b001,0,0,1,3'd0), pk(1,3'b001,0,0,1,3'd0),
                  pk(0,3'b001,1,0,1,3'd0)};
        run_trace("rst_pre");
        RST_N = 1'b0;
        tick();
        RST_N = 1'b1;
        exp_q = '{pk(1,3'b000,0,0,0,3'd0), pk(1,3'b000,0,0,0,3'd0)};
        run_trace("rst_post");
        go(3'd1);
        exp_q = '{pk(1,3'b001,0,0,1,3'd0), pk(1,3'b001,0,0,1,3'd0),
                  pk(0,3'b001,1,0,1,3'd0)};
        run_trace("rst_restart");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/logic_4053_sequencer.md
Name: logic_4053_sequencer

Overview:
- Programmable sequencer that drives the INH/A/B/C controls of a LOGIC_4053 triple 2:1 switch instance in the emulator logic library.
- Steps through a small pattern table of select codes, each held for a programmed dwell time.
- Enforces break-before-make: INH is high whenever the selects change, so COM is never driven during a transition.
- Sits between the emulator's control/register interface and the 4053 model.

Parameters:
- DEPTH, 8, number of pattern entries; power of 2, at least 2.
- DWELL_W, 16, width of the per-entry dwell count.
- BREAK_CYC, 2, cycles INH is held high before new selects are released; at least 1.

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  reset, synchronous, active-low.
- START  in  1  start-sequence pulse; sampled in IDLE only.
- STOP  in  1  abort; has priority over START.
- LOOP  in  1  on the last entry, restart at entry 0 instead of finishing; sampled continuously.
- LEN  in  log2(DEPTH)  index of the last entry used; sampled on accepted START.
- WR_EN  in  1  pattern table write strobe.
- WR_ADDR  in  log2(DEPTH)  table write address.
- WR_SEL  in  3  entry select code; bit0→A, bit1→B, bit2→C.
- WR_DWELL  in  DWELL_W  entry hold time in cycles; 0 is treated as 1.
- INH  out  1  to 4053 INH.
- A, B, C  out  1 each  to 4053 selects.
- BUSY  out  1  high in any state other than IDLE.
- STEP_IDX  out  log2(DEPTH)  index of the current entry.
- STEP_STB  out  1  one-cycle pulse on the first HOLD cycle of each entry.
- DONE  out  1  one-cycle pulse when a non-looping sequence completes.

Behaviour:
- Clock and reset: one clock, CLK. Reset RST_N is synchronous and active-low.
- Reset values: INH=1, A=B=C=0, BUSY=0, STEP_IDX=0, STEP_STB=0, DONE=0, state=IDLE. The pattern table is not reset (contents undefined until written).
- All outputs are registered.
- States: IDLE, BREAK, HOLD.
- IDLE:
  - INH=1; selects hold their last values.
  - START=1 and STOP=0 at edge t: latch LEN, idx=0, load selects from entry 0, INH=1, break counter=BREAK_CYC-1; state=BREAK from cycle t+1.
- BREAK:
  - INH=1 for exactly BREAK_CYC cycles, with A/B/C already at the new values.
  - On the last BREAK cycle: load dwell counter = max(dwell,1)-1; state=HOLD; INH=0 from the next cycle.
- HOLD:
  - INH=0; STEP_STB=1 on the first HOLD cycle only; lasts max(dwell,1) cycles.
  - On the last HOLD cycle, one of three transitions:
    - idx≠LEN: idx+1.
    - idx=LEN and LOOP=1: idx=0.
    - idx=LEN and LOOP=0: DONE=1 for one cycle, INH=1, state=IDLE.
- Same-select skip: when advancing (including a loop wrap) and the next entry's sel equals the current A/B/C, BREAK is skipped. State goes HOLD→HOLD with INH staying 0, the dwell is reloaded, and STEP_STB pulses.
- Otherwise the next entry's selects are loaded and the state goes to BREAK.
- STOP=1 in any state:
  - Next cycle: state=IDLE, INH=1, selects hold their values.
  - No DONE, no STEP_STB.
  - START in the same cycle is ignored.
- Table writes:
  - WR_EN with BUSY=0 writes {WR_SEL, WR_DWELL} to WR_ADDR.
  - WR_EN with BUSY=1 is ignored; running contents stay stable.
  - Write and START in the same IDLE cycle: the write completes and entry 0 is read after the write (write-first).
- START while BUSY is ignored.
- LEN=0 runs a single entry.
- Dwell width: the counter is DWELL_W bits. Maximum hold is 2^DWELL_W-1 cycles; no wrap.
- Reset mid-sequence: immediate return to the reset values on the next edge.

Decomposition:
- Shared package logic_seq_pkg: state enum (IDLE, BREAK, HOLD), entry struct {sel[2:0], dwell}, and function dwell_eff(d) = (d==0)?1:d.
- One sub-module: logic_seq_table, a DEPTH-entry register file with synchronous write-first read and a combinational read port.
- The FSM and counters stay in the top level.

Test Plan:
- Table {0:sel=3'b001,dwell=4; 1:sel=3'b110,dwell=2}, LEN=1, LOOP=0, START → cycles in order:
  - 2 cycles INH=1 with ABC=100.
  - 4 cycles INH=0.
  - 2 cycles INH=1 with ABC=011.
  - 2 cycles INH=0.
  - DONE pulse, then INH=1, BUSY=0.
  - STEP_STB pulses at the first HOLD cycle of each entry.
- Entries 0 and 1 both sel=3'b101, dwell=3, LEN=1 → a single BREAK of 2 cycles, then 6 contiguous cycles INH=0; 2 STEP_STB pulses, STEP_IDX 0 then 1.
- LOOP=1, LEN=1, 10 full passes → STEP_IDX sequence 0,1,0,1,… and no DONE. Deasserting LOOP during entry 1 gives DONE at the end of that entry.
- STOP asserted in the 2nd HOLD cycle of entry 0 → next cycle INH=1, BUSY=0, ABC unchanged, no DONE.
- dwell=0 with LEN=0 → exactly 1 HOLD cycle. WR_EN to entry 0 with sel=3'b111 while BUSY=1 → entry 0 unchanged on rerun.
- RST_N=0 for one cycle mid-HOLD → INH=1, ABC=000, BUSY=0, outputs quiet. START after release is accepted.
